// File: rtl/dlsc_demosaic_vng_out_stream.sv
// VNG demosaic output stage: pairs buffered centre pixels with their colour
// corrections, saturates, routes to RGB and streams out with backpressure.
module dlsc_demosaic_vng_out_stream #(
    parameter int DATA   = 8,
    parameter int CDEPTH = 16,
    parameter int PRIME  = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_data,
    input  logic [1:0]      in_color,
    input  logic            in_masked,
    input  logic            in_sof,
    input  logic            diff_valid,
    output logic            diff_ready,
    input  logic [DATA:0]   diff_a,
    input  logic [DATA:0]   diff_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_red,
    output logic [DATA-1:0] out_green,
    output logic [DATA-1:0] out_blue,
    output logic [15:0]     stat_clip
);

    // Every port pair follows valid/ready: a transfer happens on a rising edge
    // where both are high; valid never waits on ready, ready may depend on valid.

    localparam int AW = $clog2(CDEPTH);
    localparam int FW = DATA + 4;
    localparam int PW = (PRIME < 1) ? 1 : $clog2(PRIME + 1);

    // centre FIFO
    logic [FW-1:0]   mem [CDEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            alive;
    logic [FW-1:0]   head;
    logic            h_sof;
    logic            h_masked;
    logic [1:0]      h_color;
    logic [DATA-1:0] h_data;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = alive && !full;
    assign push     = in_valid && in_ready;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign h_sof    = head[DATA+3];
    assign h_masked = head[DATA+2];
    assign h_color  = head[DATA+1:DATA];
    assign h_data   = head[DATA-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_sof, in_masked, in_color, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            alive  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // S1 stage and handshake
    logic              s1_v;
    logic              s1_keep;
    logic [DATA-1:0]   s1_px;
    logic [1:0]        s1_color;
    logic [DATA+1:0]   s1_sum_a;
    logic [DATA+1:0]   s1_sum_b;
    logic              out_move;
    logic              s1_load;

    assign out_move   = !out_valid || out_ready;
    // Dropped entries leave S1 regardless of the output register.
    assign s1_load    = !s1_v || !s1_keep || out_move;
    assign diff_ready = !empty && s1_load;
    assign pop        = diff_valid && diff_ready;

    // priming
    logic [PW-1:0]   prime_cnt;
    logic [PW-1:0]   pop_idx;
    logic [PW-1:0]   prime_next;
    logic            pop_keep;
    logic [DATA+1:0] sum_a;
    logic [DATA+1:0] sum_b;

    assign pop_idx    = h_sof ? '0 : prime_cnt;
    assign pop_keep   = (pop_idx >= PW'(PRIME)) && !h_masked;
    assign prime_next = (pop_idx == PW'(PRIME)) ? pop_idx : pop_idx + PW'(1);
    assign sum_a      = {2'b00, h_data} + {diff_a[DATA], diff_a};
    assign sum_b      = {2'b00, h_data} + {diff_b[DATA], diff_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
            s1_v      <= 1'b0;
            s1_keep   <= 1'b0;
            s1_px     <= '0;
            s1_color  <= '0;
            s1_sum_a  <= '0;
            s1_sum_b  <= '0;
        end else begin
            if (pop) prime_cnt <= prime_next;
            if (s1_load) begin
                s1_v    <= pop;
                s1_keep <= pop && pop_keep;
                if (pop) begin
                    s1_px    <= h_data;
                    s1_color <= h_color;
                    s1_sum_a <= sum_a;
                    s1_sum_b <= sum_b;
                end
            end
        end
    end

    // saturation and colour routing
    function automatic logic [DATA-1:0] sat_val(input logic [DATA+1:0] s);
        if (s[DATA+1])  return '0;
        else if (s[DATA]) return '1;
        else            return s[DATA-1:0];
    endfunction

    logic [DATA-1:0] sat_a;
    logic [DATA-1:0] sat_b;
    logic [1:0]      clip_n;
    logic [DATA-1:0] nxt_red;
    logic [DATA-1:0] nxt_green;
    logic [DATA-1:0] nxt_blue;
    logic [16:0]     stat_sum;
    logic [15:0]     stat_next;

    always_comb begin
        sat_a     = sat_val(s1_sum_a);
        sat_b     = sat_val(s1_sum_b);
        clip_n    = {1'b0, s1_sum_a[DATA+1] | s1_sum_a[DATA]}
                  + {1'b0, s1_sum_b[DATA+1] | s1_sum_b[DATA]};
        nxt_red   = sat_a;
        nxt_green = s1_px;
        nxt_blue  = sat_b;
        case (s1_color)
            2'd0: begin
                nxt_red   = s1_px;
                nxt_green = sat_a;
                nxt_blue  = sat_b;
            end
            2'd3: begin
                nxt_red   = sat_a;
                nxt_green = sat_b;
                nxt_blue  = s1_px;
            end
            default: ;
        endcase
        stat_sum  = {1'b0, stat_clip} + 17'(clip_n);
        stat_next = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            stat_clip <= '0;
        end else if (out_move) begin
            out_valid <= s1_v && s1_keep;
            if (s1_v && s1_keep) begin
                out_red   <= nxt_red;
                out_green <= nxt_green;
                out_blue  <= nxt_blue;
                stat_clip <= stat_next;
            end
        end
    end

endmodule
